zelda_collision_probe: RTL and testbench
========================================

# zelda_collision_probe

Walkability checker that sits directly upstream of `background_collision_rom`. It drives that ROM's `collision_address` port and consumes `q_collision`. For each requested sprite position it probes the four inset corners of the sprite's bounding box in the 500x500 collision map. It then reports pass/block to the movement controller, with a fixed latency so movement logic can schedule around it.

## Interface
Parameters:
- `MAP_W`, default 500: collision map width in pixels (row stride).
- `MAP_H`, default 500: collision map height in pixels.
- `SPRITE_W`, default 32: sprite bounding-box width.
- `SPRITE_H`, default 32: sprite bounding-box height.
- `INSET`, default 4: corner inset in pixels, applied on all four sides.
- `WALKABLE`, default 4'h0: the only collision code treated as passable.

Ports:
- `clock`, in, 1: single clock; all state on its rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: request to check position (`pos_x`, `pos_y`).
- `pos_x`, in, 10: candidate sprite top-left X.
- `pos_y`, in, 10: candidate sprite top-left Y.
- `busy`, out, 1: check in progress; `req` is ignored while high.
- `done`, out, 1: one-cycle pulse; result outputs are valid from this cycle.
- `blocked`, out, 1: 1 when the position is not walkable.
- `hit_code`, out, 4: code that caused the block; 0 when not blocked.
- `collision_address`, out, 18: registered address to the ROM `collision_address` port.
- `q_collision`, in, 4: ROM data, registered in the ROM, 1 clock after address.

## Operation
- States: IDLE, BOUNDS, ISSUE, DRAIN, REPORT.
- IDLE:
  - When `req`=1 and `busy`=0 at an edge, latch `pos_x`/`pos_y`, set `busy`, and go to BOUNDS.
- BOUNDS:
  - Compute in 11-bit unsigned: out-of-bounds when `pos_x`+`SPRITE_W` > `MAP_W` or `pos_y`+`SPRITE_H` > `MAP_H`.
  - If out-of-bounds: go to REPORT with `blocked`=1 and `hit_code`=4'hF. No ROM access; `collision_address` holds its value.
  - Otherwise: go to ISSUE.
- Corner coordinates:
  - xl = x+`INSET`, xr = x+`SPRITE_W`-1-`INSET`.
  - yt = y+`INSET`, yb = y+`SPRITE_H`-1-`INSET`.
- Address: y*`MAP_W`+x, truncated to 18 bits. It is always less than 250000 once bounds pass.
- ISSUE: present addresses on 4 consecutive cycles in the order TL(xl,yt), TR(xr,yt), BL(xl,yb), BR(xr,yb).
- DRAIN: absorbs the 2-cycle return pipeline (registered address plus registered ROM).
- Evaluation:
  - Each returned code is compared against `WALKABLE`.
  - `hit_code` takes the first non-walkable code in TL, TR, BL, BR order; later hits do not overwrite it.
  - `blocked` is the OR of all four comparisons.
- REPORT:
  - Assert `done` for 1 cycle, deassert `busy` in the same cycle, and return to IDLE.
  - `blocked` and `hit_code` hold until the next accepted request clears them at its acceptance edge.
- `req` while busy: ignored. There is no queueing and no error flag.

## Timing
- Reset values, asynchronous on `reset_n`=0:
  - `busy`=0, `done`=0, `blocked`=0, `hit_code`=0, `collision_address`=0.
  - State = IDLE.
- Reset mid-check: in-flight probes are discarded and no `done` is produced. After release, the first edge with `req`=1 is accepted normally.
- Cycle labels: let E0 be the acceptance edge, Ek the k-th edge after E0.
- In-bounds check:
  - `collision_address` = TL after E1, TR after E2, BL after E3, BR after E4.
  - TL data is sampled at E3 and BR data at E6.
  - `done`=1 for the cycle between E6 and E7, so latency is 6 clocks.
- Out-of-bounds check: `done`=1 for the cycle between E1 and E2, so latency is 1 clock.
- Back-to-back requests: if `req`=1 during the `done` cycle, that request is accepted at the following edge. Throughput is 1 check per 7 clocks.
- `collision_address` only changes during ISSUE.

## Test plan
- All-walkable map, req at (100,100):
  - `collision_address` sequence is 52104, 52127, 63604, 63627 after E1 through E4.
  - `done` comes after E6 with `blocked`=0 and `hit_code`=0.
- Map with code 3 only at 63627, req at (100,100): `blocked`=1 and `hit_code`=3 at `done`.
- Map with TR=2 and BL=5, req at (100,100): `hit_code`=2 (first-hit priority) and `blocked`=1.
- Bounds edge cases:
  - req at (468,0) is in bounds and gets a full probe with `done` after E6.
  - req at (469,0) gives `done` after E1, `blocked`=1, `hit_code`=F, and no address change.
  - req at (0,469) behaves the same as (469,0).
- Pulse `req` at E2 and E4 of an active check: both ignored, with exactly one `done` produced.
- Hold `req` continuously: a `done` pulse every 7 cycles.
- Reset and restart:
  - Assert `reset_n`=0 after E3: all outputs drop to 0 immediately and no `done` appears.
  - A post-reset req at (100,100) then completes correctly.

Source files
------------

// File: rtl/zelda_collision_probe.sv
// Walkability probe in front of background_collision_rom: checks the four inset
// corners of a sprite bounding box and reports pass/block with fixed latency.
module zelda_collision_probe #(
    parameter int          MAP_W    = 500,
    parameter int          MAP_H    = 500,
    parameter int          SPRITE_W = 32,
    parameter int          SPRITE_H = 32,
    parameter int          INSET    = 4,
    parameter logic [3:0]  WALKABLE = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic        busy,
    output logic        done,
    output logic        blocked,
    output logic [3:0]  hit_code,
    output logic [17:0] collision_address,
    input  logic [3:0]  q_collision
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BOUNDS = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [10:0] MAP_W_L    = 11'(MAP_W);
    localparam logic [10:0] MAP_H_L    = 11'(MAP_H);
    localparam logic [10:0] SPRITE_W_L = 11'(SPRITE_W);
    localparam logic [10:0] SPRITE_H_L = 11'(SPRITE_H);

    logic [2:0]  state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic [2:0]  cyc_q, cyc_d;
    logic [17:0] addr_q, addr_d;
    logic        done_q, done_d;
    logic        blocked_q, blocked_d;
    logic [3:0]  hit_q, hit_d;

    logic        accept;
    logic        out_of_bounds;
    logic        sample_en;
    logic [1:0]  corner_sel;
    logic [17:0] xl, xr, yt, yb, cx, cy;
    logic [17:0] corner_addr;

    // A new request is taken in IDLE or during the REPORT (done) cycle.
    assign accept = req && ((state_q == S_IDLE) || (state_q == S_REPORT));

    assign out_of_bounds = (({1'b0, pos_x_q} + SPRITE_W_L) > MAP_W_L) ||
                           (({1'b0, pos_y_q} + SPRITE_H_L) > MAP_H_L);

    assign xl = 18'(pos_x_q) + 18'(INSET);
    assign xr = 18'(pos_x_q) + 18'(SPRITE_W - 1 - INSET);
    assign yt = 18'(pos_y_q) + 18'(INSET);
    assign yb = 18'(pos_y_q) + 18'(SPRITE_H - 1 - INSET);

    // Corner order TL, TR, BL, BR: bit0 selects right, bit1 selects bottom.
    assign corner_sel  = (state_q == S_BOUNDS) ? 2'd0 : 2'(cyc_q + 3'd1);
    assign cx          = corner_sel[0] ? xr : xl;
    assign cy          = corner_sel[1] ? yb : yt;
    assign corner_addr = cy * 18'(MAP_W) + cx;

    // ROM data for the corner issued two edges earlier arrives while cyc_q is 1..4.
    assign sample_en = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (cyc_q != 3'd0);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no latch is inferred.
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cyc_d     = cyc_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        blocked_d = blocked_q;
        hit_d     = hit_q;

        if (sample_en && (q_collision != WALKABLE)) begin
            blocked_d = 1'b1;
            if (!blocked_q) hit_d = q_collision;
        end

        case (state_q)
            S_IDLE, S_REPORT: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d   = S_BOUNDS;
                    pos_x_d   = pos_x;
                    pos_y_d   = pos_y;
                    blocked_d = 1'b0;
                    hit_d     = 4'h0;
                end
            end
            S_BOUNDS: begin
                if (out_of_bounds) begin
                    state_d   = S_REPORT;
                    done_d    = 1'b1;
                    blocked_d = 1'b1;
                    hit_d     = 4'hF;
                end else begin
                    state_d = S_ISSUE;
                    addr_d  = corner_addr;
                    cyc_d   = 3'd0;
                end
            end
            S_ISSUE: begin
                addr_d = corner_addr;
                cyc_d  = cyc_q + 3'd1;
                if (cyc_q == 3'd2) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cyc_d = cyc_q + 3'd1;
                if (cyc_q == 3'd4) begin
                    state_d = S_REPORT;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            cyc_q     <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            hit_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
            hit_q     <= hit_d;
        end
    end

    assign busy              = (state_q == S_BOUNDS) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done              = done_q;
    assign blocked           = blocked_q;
    assign hit_code          = hit_q;
    assign collision_address = addr_q;

endmodule

// File: tb/tb_zelda_collision_probe.sv
// Scoreboard bench for zelda_collision_probe with a behavioural registered
// collision ROM (walkable everywhere except explicit overrides).
module tb_zelda_collision_probe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        busy, done, blocked;
    logic [3:0]  hit_code;
    logic [17:0] collision_address;
    logic [3:0]  q_collision = 4'h0;

    zelda_collision_probe dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req               (req),
        .pos_x             (pos_x),
        .pos_y             (pos_y),
        .busy              (busy),
        .done              (done),
        .blocked           (blocked),
        .hit_code          (hit_code),
        .collision_address (collision_address),
        .q_collision       (q_collision)
    );

    always #5 clock = ~clock;

    logic [3:0] map_ovr [int];

    function automatic logic [3:0] rom_code(input int a);
        return map_ovr.exists(a) ? map_ovr[a] : 4'h0;
    endfunction

    always @(posedge clock) q_collision <= rom_code(int'(collision_address));

    typedef struct {
        int         done_cyc;
        logic       blk;
        logic [3:0] hit;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_push = 0;
    int   n_done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int corner_addr(input int x, input int y, input int k);
        int cx, cy;
        cx = (k % 2 == 1) ? x + 27 : x + 4;
        cy = (k >= 2) ? y + 27 : y + 4;
        return cy * 500 + cx;
    endfunction

    function automatic void model(input int x, input int y, output bit inb,
                                  output logic blk, output logic [3:0] hit);
        logic [3:0] c;
        inb = (x + 32 <= 500) && (y + 32 <= 500);
        blk = 1'b0;
        hit = 4'h0;
        if (!inb) begin
            blk = 1'b1;
            hit = 4'hF;
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = rom_code(corner_addr(x, y, k));
                if (c != 4'h0 && !blk) hit = c;
                if (c != 4'h0) blk = 1'b1;
            end
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("blocked", blocked, e.blk);
                check("hit_code", hit_code, e.hit);
                check("busy_in_done", busy, 1'b0);
            end
        end
    end

    task automatic push_exp(input int x, input int y, input int acc);
        bit inb;
        exp_t e;
        model(x, y, inb, e.blk, e.hit);
        e.done_cyc = acc + (inb ? 6 : 1);
        sb.push_back(e);
        n_push++;
    endtask

    // Drive one request; poke=1 pulses req (with a different position) at E2 and E4.
    task automatic run_req(input int x, input int y, input bit poke);
        int acc;
        bit inb;
        logic blk_m;
        logic [3:0] hit_m;
        logic [17:0] prev_addr;
        model(x, y, inb, blk_m, hit_m);
        @(negedge clock);
        prev_addr = collision_address;
        pos_x = 10'(x);
        pos_y = 10'(y);
        req = 1'b1;
        @(posedge clock);
        #1 acc = cyc;
        push_exp(x, y, acc);
        @(negedge clock);
        req = 1'b0;
        if (inb) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                check($sformatf("addr_c%0d", k), collision_address, corner_addr(x, y, k));
                check($sformatf("busy_c%0d", k), busy, 1'b1);
                if (poke) begin
                    req   = (k == 0 || k == 2);
                    pos_x = 10'd469;
                    pos_y = 10'd0;
                end
            end
        end else begin
            @(negedge clock);
            check("addr_hold_oob", collision_address, prev_addr);
        end
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check("timeout_pending", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int acc;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_blocked", blocked, 1'b0);
        check("rst_hit", hit_code, 4'h0);
        check("rst_addr", collision_address, 18'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // All-walkable probe at (100,100): addresses 52104, 52127, 63604, 63627.
        run_req(100, 100, 1'b0);
        wait_idle();

        map_ovr[63627] = 4'h3;
        run_req(100, 100, 1'b0);
        wait_idle();
        map_ovr.delete();

        map_ovr[52127] = 4'h2;
        map_ovr[63604] = 4'h5;
        run_req(100, 100, 1'b0);
        wait_idle();
        map_ovr.delete();

        run_req(468, 0, 1'b0);
        wait_idle();
        run_req(469, 0, 1'b0);
        wait_idle();
        run_req(0, 469, 1'b0);
        wait_idle();

        // Requests pulsed at E2 and E4 must be ignored.
        run_req(100, 100, 1'b1);
        wait_idle();
        repeat (10) @(negedge clock);

        // Held request: one done every 7 clocks.
        map_ovr[52104] = 4'h7;
        @(negedge clock);
        pos_x = 10'd100;
        pos_y = 10'd100;
        req = 1'b1;
        @(posedge clock);
        #1 acc = cyc;
        push_exp(100, 100, acc);
        push_exp(100, 100, acc + 7);
        push_exp(100, 100, acc + 14);
        for (int i = 0; i < 40 && cyc < acc + 20; i++) @(negedge clock);
        req = 1'b0;
        wait_idle();
        map_ovr.delete();

        // Reset mid-check after E3.
        @(negedge clock);
        pos_x = 10'd100;
        pos_y = 10'd100;
        req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_blocked", blocked, 1'b0);
        check("midrst_hit", hit_code, 4'h0);
        check("midrst_addr", collision_address, 18'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        map_ovr[52127] = 4'h9;
        run_req(100, 100, 1'b0);
        wait_idle();
        map_ovr.delete();

        check("done_count", n_done, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
